// File: rtl/cmd_host_issuer.sv
// -----------------------------------------------------------------------------
// cmd_host_issuer
// Host-side initiator for the 8-bit CPU command channel of the SRIO bridge.
// Sends a one-byte self-check request (CMD_CODE) on an AXIS master, waits for
// the one-byte feedback on an AXIS slave, and re-sends after NOT_READY or a
// response timeout up to MAX_RETRY times before reporting the final status.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   start_in               one-cycle request to run a self-check (IDLE only)
//   busy_out               high whenever the FSM is not idle
//   done_out               one-cycle pulse when the sequence finishes
//   status_out             00 none, 01 ready, 10 not-ready, 11 timeout
//   retry_cnt_out          re-sends used in the current/last sequence
//   rsp_err_out            sticky: unknown or stray response byte seen
//   cmd_axis_*             command AXIS master (single-beat packets)
//   rsp_axis_*             feedback AXIS slave (always accepted, no tready)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start_in
// S_SEND     | command beat presented, held until tready
// S_WAIT_RSP | response timer running, waiting for a feedback byte
// S_GAP      | idle spacing before a re-send
// S_DONE     | one-cycle done pulse, status valid
// -----------------------------------------------------------------------------
module cmd_host_issuer #(
    parameter int         TIMEOUT_WIDTH  = 12,
    parameter int         TIMEOUT_CYCLES = 2000,
    parameter int         MAX_RETRY      = 3,
    parameter int         RETRY_GAP      = 16,
    parameter logic [7:0] CMD_CODE       = 8'h21,
    parameter logic [7:0] RSP_READY      = 8'h25,
    parameter logic [7:0] RSP_NOT_READY  = 8'h2a
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_in,
    output logic       busy_out,
    output logic       done_out,
    output logic [1:0] status_out,
    output logic [3:0] retry_cnt_out,
    output logic       rsp_err_out,
    output logic [7:0] cmd_axis_tdata_out,
    output logic       cmd_axis_tvalid_out,
    output logic       cmd_axis_tlast_out,
    input  logic       cmd_axis_tready_in,
    input  logic [7:0] rsp_axis_tdata_in,
    input  logic       rsp_axis_tvalid_in,
    input  logic       rsp_axis_tlast_in
);

    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX    = '1;
    localparam logic [GAP_W-1:0]         GAP_LOAD     = GAP_W'(RETRY_GAP - 1);
    localparam logic [3:0]               MAX_RETRY_C  = 4'(MAX_RETRY);

    localparam logic [1:0] ST_NONE      = 2'b00;
    localparam logic [1:0] ST_READY     = 2'b01;
    localparam logic [1:0] ST_NOT_READY = 2'b10;
    localparam logic [1:0] ST_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RSP,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic [TIMEOUT_WIDTH-1:0] timer_inc;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [3:0]               retry_q, retry_d;
    logic [1:0]               status_q, status_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     attempt_failed;
    logic [1:0]               fail_code;

    // The feedback tlast carries no information for a single-byte response.
    logic unused_rsp_tlast;
    assign unused_rsp_tlast = rsp_axis_tlast_in;

    // Saturating increment so a long run of junk bytes can never wrap the timer.
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMEOUT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            gap_q     <= '0;
            retry_q   <= '0;
            status_q  <= ST_NONE;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            retry_q   <= retry_d;
            status_q  <= status_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        gap_d          = gap_q;
        retry_d        = retry_q;
        status_d       = status_q;
        rsp_err_d      = rsp_err_q;
        attempt_failed = 1'b0;
        fail_code      = ST_NONE;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d   = S_SEND;
                    status_d  = ST_NONE;
                    retry_d   = '0;
                    rsp_err_d = 1'b0;
                end
            end
            S_SEND: begin
                if (cmd_axis_tready_in) begin
                    state_d = S_WAIT_RSP;
                    timer_d = '0;
                end
            end
            S_WAIT_RSP: begin
                // A valid byte in the timeout cycle takes precedence over the timeout.
                if (rsp_axis_tvalid_in) begin
                    if (rsp_axis_tdata_in == RSP_READY) begin
                        state_d  = S_DONE;
                        status_d = ST_READY;
                    end else if (rsp_axis_tdata_in == RSP_NOT_READY) begin
                        attempt_failed = 1'b1;
                        fail_code      = ST_NOT_READY;
                    end else begin
                        rsp_err_d = 1'b1;
                        timer_d   = timer_inc;
                    end
                end else if (timer_q >= TIMEOUT_LAST) begin
                    // >= rather than == : a junk byte in the last cycle pushes the
                    // timer past TIMEOUT_LAST and the timeout must still fire.
                    attempt_failed = 1'b1;
                    fail_code      = ST_TIMEOUT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (attempt_failed) begin
            if (retry_q < MAX_RETRY_C) begin
                retry_d = retry_q + 4'd1;
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
            end else begin
                state_d  = S_DONE;
                status_d = fail_code;
            end
        end

        // Bytes arriving while no response is expected are flagged but otherwise ignored.
        if (rsp_axis_tvalid_in && (state_q != S_WAIT_RSP)) begin
            rsp_err_d = 1'b1;
        end
    end

    assign busy_out            = (state_q != S_IDLE);
    assign done_out            = (state_q == S_DONE);
    assign status_out          = status_q;
    assign retry_cnt_out       = retry_q;
    assign rsp_err_out         = rsp_err_q;
    assign cmd_axis_tvalid_out = (state_q == S_SEND);
    assign cmd_axis_tlast_out  = (state_q == S_SEND);
    assign cmd_axis_tdata_out  = (state_q == S_SEND) ? CMD_CODE : 8'h00;

endmodule

// File: tb/tb_cmd_host_issuer.sv
module tb_cmd_host_issuer;

    localparam int         TW   = 12;
    localparam int         TC   = 2000;
    localparam int         MR   = 3;
    localparam int         RG   = 16;
    localparam logic [7:0] CMD  = 8'h21;
    localparam logic [7:0] RDY  = 8'h25;
    localparam logic [7:0] NRDY = 8'h2a;

    localparam int K_RDY = 0;
    localparam int K_NR  = 1;
    localparam int K_TO  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_in;
    logic       busy_out;
    logic       done_out;
    logic [1:0] status_out;
    logic [3:0] retry_cnt_out;
    logic       rsp_err_out;
    logic [7:0] cmd_tdata;
    logic       cmd_tvalid;
    logic       cmd_tlast;
    logic       cmd_tready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_last;

    cmd_host_issuer #(
        .TIMEOUT_WIDTH (TW),
        .TIMEOUT_CYCLES(TC),
        .MAX_RETRY     (MR),
        .RETRY_GAP     (RG),
        .CMD_CODE      (CMD),
        .RSP_READY     (RDY),
        .RSP_NOT_READY (NRDY)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start_in           (start_in),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .status_out         (status_out),
        .retry_cnt_out      (retry_cnt_out),
        .rsp_err_out        (rsp_err_out),
        .cmd_axis_tdata_out (cmd_tdata),
        .cmd_axis_tvalid_out(cmd_tvalid),
        .cmd_axis_tlast_out (cmd_tlast),
        .cmd_axis_tready_in (cmd_tready),
        .rsp_axis_tdata_in  (rsp_data),
        .rsp_axis_tvalid_in (rsp_valid),
        .rsp_axis_tlast_in  (rsp_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Independent beat counter: samples the handshake well after the input update.
    int beats = 0;
    always begin
        @(negedge clk);
        #1;
        if (!reset && cmd_tvalid && cmd_tready) beats++;
    end

    int checks = 0;
    int errors = 0;

    // Per-attempt scenario: response kind, response delay (cycles after the
    // handshake), junk byte before the response, and tready stall length.
    int kind [MR+1];
    int dly  [MR+1];
    int junk [MR+1];
    int stall[MR+1];
    bit poke_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tvalid(input string tag);
        int n;
        n = 0;
        while (cmd_tvalid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_send_seen"}, 32'(cmd_tvalid), 32'd1);
    endtask

    task automatic run_seq(input string tag);
        int n_used, exp_status, exp_err, beats0, h, e, n, d;
        bit found;
        // Reference outcome from the retry rules.
        n_used = MR + 1;
        found  = 1'b0;
        for (int i = 0; i <= MR; i++) begin
            if (!found && kind[i] == K_RDY) begin
                n_used = i + 1;
                found  = 1'b1;
            end
        end
        exp_status = (kind[n_used-1] == K_RDY) ? 1 : (kind[n_used-1] == K_NR) ? 2 : 3;
        exp_err = 0;
        for (int i = 0; i < n_used; i++) if (junk[i] != 0) exp_err = 1;

        beats0 = beats;
        e      = 0;
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;

        for (int a = 0; a < n_used; a++) begin
            wait_tvalid(tag);
            if (a > 0) chk({tag, "_gap_timing"}, 32'(cyc), 32'(e + RG + 1));
            chk({tag, "_tdata"}, 32'(cmd_tdata), 32'(CMD));
            chk({tag, "_tlast"}, 32'(cmd_tlast), 32'd1);
            chk({tag, "_busy"}, 32'(busy_out), 32'd1);
            chk({tag, "_retry_mid"}, 32'(retry_cnt_out), 32'(a));
            chk({tag, "_status_mid"}, 32'(status_out), 32'd0);
            if (a == 0) chk({tag, "_err_cleared"}, 32'(rsp_err_out), 32'd0);

            for (int s = 0; s < stall[a]; s++) begin
                cmd_tready = 1'b0;
                @(negedge clk);
                chk({tag, "_stall_hold"}, {23'd0, cmd_tvalid, cmd_tdata}, {23'd0, 1'b1, CMD});
            end
            cmd_tready = 1'b1;
            h = cyc;
            @(negedge clk);
            chk({tag, "_no_dup"}, 32'(cmd_tvalid), 32'd0);
            cmd_tready = 1'b0;

            if (kind[a] == K_TO) begin
                e = h + TC;
                start_in = poke_start && (a == 0);
                @(negedge clk);
                start_in = 1'b0;
            end else begin
                d = dly[a];
                for (int k = 0; k <= d; k++) begin
                    start_in = poke_start && (a == 0) && (k == 0);
                    if (k == d) begin
                        rsp_valid = 1'b1;
                        rsp_last  = 1'b1;
                        rsp_data  = (kind[a] == K_RDY) ? RDY : NRDY;
                    end else if (junk[a] != 0 && k == 0) begin
                        rsp_valid = 1'b1;
                        rsp_last  = 1'b1;
                        rsp_data  = 8'h55;
                    end else begin
                        rsp_valid = 1'b0;
                        rsp_last  = 1'b0;
                    end
                    @(negedge clk);
                end
                start_in  = 1'b0;
                rsp_valid = 1'b0;
                rsp_last  = 1'b0;
                e = h + 1 + d;
            end
        end

        n = 0;
        while (done_out !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done_out), 32'd1);
        chk({tag, "_done_timing"}, 32'(cyc), 32'(e + 1));
        chk({tag, "_status"}, 32'(status_out), 32'(exp_status));
        chk({tag, "_retry"}, 32'(retry_cnt_out), 32'(n_used - 1));
        chk({tag, "_rsp_err"}, 32'(rsp_err_out), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done_out), 32'd0);
        chk({tag, "_idle"}, 32'(busy_out), 32'd0);
        chk({tag, "_beats"}, 32'(beats - beats0), 32'(n_used));
        @(negedge clk);
        chk({tag, "_stay_idle"}, 32'(busy_out), 32'd0);
        chk({tag, "_status_held"}, 32'(status_out), 32'(exp_status));
    endtask

    task automatic set_all(input int k, input int dl, input int jk, input int st);
        for (int i = 0; i <= MR; i++) begin
            kind[i]  = k;
            dly[i]   = dl;
            junk[i]  = jk;
            stall[i] = st;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy0"}, 32'(busy_out), 32'd0);
        chk({tag, "_done0"}, 32'(done_out), 32'd0);
        chk({tag, "_status0"}, 32'(status_out), 32'd0);
        chk({tag, "_retry0"}, 32'(retry_cnt_out), 32'd0);
        chk({tag, "_err0"}, 32'(rsp_err_out), 32'd0);
        chk({tag, "_axis0"}, {22'd0, cmd_tvalid, cmd_tlast, cmd_tdata}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x;
        reset      = 1'b1;
        start_in   = 1'b0;
        cmd_tready = 1'b0;
        rsp_data   = 8'h00;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        poke_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // T1: immediate ready sink, READY five cycles after the handshake
        set_all(K_RDY, 5, 0, 0);
        run_seq("T1");

        // T2: sink holds tready low for 7 cycles
        set_all(K_RDY, 3, 0, 7);
        run_seq("T2");

        // T3: NOT_READY on every attempt
        set_all(K_NR, 4, 0, 0);
        run_seq("T3");

        // T4: no response at all
        set_all(K_TO, 0, 0, 0);
        run_seq("T4");

        // T5: junk byte then READY
        set_all(K_RDY, 6, 1, 0);
        run_seq("T5");

        // Stray byte in IDLE sets the sticky error; next start clears it
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_err", 32'(rsp_err_out), 32'd1);
        chk("stray_status_held", 32'(status_out), 32'd1);
        chk("stray_idle", 32'(busy_out), 32'd0);

        // Randomized sequences
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i <= MR; i++) begin
                x = int'($urandom_range(0, 9));
                kind[i]  = (x < 4) ? K_RDY : (x < 8) ? K_NR : K_TO;
                dly[i]   = int'($urandom_range(0, 30));
                junk[i]  = (kind[i] != K_TO && dly[i] > 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
                stall[i] = int'($urandom_range(0, 4));
            end
            run_seq("rnd");
        end

        // T6: reset in WAIT_RSP during the second attempt
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        wait_tvalid("T6a");
        cmd_tready = 1'b1;
        @(negedge clk);
        cmd_tready = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = NRDY;
        @(negedge clk);
        rsp_valid = 1'b0;
        wait_tvalid("T6b");
        cmd_tready = 1'b1;
        @(negedge clk);
        cmd_tready = 1'b0;
        rsp_valid  = 1'b1;
        rsp_data   = 8'h55;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("T6_pre_retry", 32'(retry_cnt_out), 32'd1);
        chk("T6_pre_err", 32'(rsp_err_out), 32'd1);
        chk("T6_pre_busy", 32'(busy_out), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("T6_rst");
        reset = 1'b0;
        @(negedge clk);

        // Clean run after reset, with a start pulse while busy that must be ignored
        set_all(K_RDY, 6, 0, 1);
        poke_start = 1'b1;
        run_seq("T6c");
        poke_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
